// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame FSM encoding and
// keyboard protocol bytes.
package ps2_pkg;

  typedef logic [1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE   = 2'd0;
  localparam ps2_state_t ST_DATA   = 2'd1;
  localparam ps2_state_t ST_PARITY = 2'd2;
  localparam ps2_state_t ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_REL    = 8'hF0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVR0   = 8'h00;
  localparam logic [7:0] PS2_OVR1   = 8'hFF;

  // Device status/response bytes that never describe a key.
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_OVR0) || (b == PS2_OVR1);
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: line conditioning, 11-bit deframing, parity/stop and
// timeout checking, saturating error counter. Shared by keyboard and mouse.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 112000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       raw_valid,
  output logic [7:0] raw_byte,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0] line_in;
  logic [1:0] filt;

  assign line_in = {ps2_data, ps2_clk};

  // Per line: 2-FF synchronizer, then a run-length filter preset high.
  for (genvar i = 0; i < 2; i++) begin : g_line
    logic       sync1_q, sync2_q, filt_q;
    logic [7:0] run_q;

    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        run_q   <= '0;
      end else begin
        sync1_q <= line_in[i];
        sync2_q <= sync1_q;
        if (sync2_q == filt_q) begin
          run_q <= '0;
        end else if (run_q == 8'(FILTER_LEN - 1)) begin
          run_q  <= '0;
          filt_q <= sync2_q;
        end else begin
          run_q <= run_q + 8'd1;
        end
      end
    end

    assign filt[i] = filt_q;
  end

  logic            clk_prev_q;
  logic            fall;
  logic            data_bit;
  ps2_state_t      state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      sreg_q;
  logic            par_q;
  logic [TW-1:0]   to_cnt_q;
  logic            timeout_hit;
  logic            frame_ok;
  logic            err_event;

  assign fall     = clk_prev_q & ~filt[0];
  assign data_bit = filt[1];

  always_comb begin
    timeout_hit = 1'b0;
    frame_ok    = 1'b0;
    err_event   = 1'b0;
    if (!fall && state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      timeout_hit = 1'b1;
    end
    if (fall && state_q == ST_STOP) begin
      frame_ok = data_bit && (^{sreg_q, par_q});
    end
    err_event = timeout_hit || (fall && state_q == ST_STOP && !frame_ok);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sreg_q     <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      raw_valid  <= 1'b0;
      raw_byte   <= '0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      clk_prev_q <= filt[0];
      raw_valid  <= frame_ok;
      frame_err  <= err_event;
      if (frame_ok) raw_byte <= sreg_q;
      if (err_event && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (fall) begin
        to_cnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!data_bit) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            sreg_q    <= {data_bit, sreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= data_bit;
            state_q <= ST_STOP;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q == ST_IDLE || timeout_hit) begin
        to_cnt_q <= '0;
        state_q  <= ST_IDLE;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: byte receiver plus E0/F0 prefix folding into one
// key event per make/break code.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 112000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       raw_valid,
  output logic [7:0] raw_byte,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  logic ext_q, rel_q;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .raw_valid (raw_valid),
    .raw_byte  (raw_byte),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      // A broken frame may have been part of a prefixed sequence; drop it.
      if (frame_err) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end else if (raw_valid) begin
        if (raw_byte == PS2_EXT) begin
          ext_q <= 1'b1;
        end else if (raw_byte == PS2_REL) begin
          rel_q <= 1'b1;
        end else begin
          if (!is_status(raw_byte)) begin
            key_valid    <= 1'b1;
            key_code     <= raw_byte;
            key_pressed  <= ~rel_q;
            key_extended <= ext_q;
          end
          ext_q <= 1'b0;
          rel_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: directed PS/2 frames with hand-computed
// expectations queued at stimulus time and checked by a negedge monitor.
module tb_ps2_kbd_rx;

  localparam int FLT  = 3;
  localparam int TO   = 300;
  localparam int HALF = 8;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       raw_valid, key_valid, key_pressed, key_extended, frame_err;
  logic [7:0] raw_byte, key_code, err_cnt;

  typedef struct packed {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } key_t;

  logic [7:0] raw_q[$];
  key_t       key_q[$];
  logic [7:0] err_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       raw_prev = 1'b0;
  key_t       mon_k;

  ps2_kbd_rx #(
    .FILTER_LEN  (FLT),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .raw_valid    (raw_valid),
    .raw_byte     (raw_byte),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=no strobe", name, act);
  endtask

  always @(negedge clk_sys) begin
    if (raw_valid) begin
      if (raw_q.size() == 0) unexpected("raw_unexpected", raw_byte);
      else check("raw_byte", raw_byte, raw_q.pop_front());
    end
    if (key_valid) begin
      check("key_one_cycle_after_raw", raw_prev, 1);
      if (key_q.size() == 0) begin
        unexpected("key_unexpected", key_code);
      end else begin
        mon_k = key_q.pop_front();
        check("key_code", key_code, mon_k.code);
        check("key_pressed", key_pressed, mon_k.pressed);
        check("key_extended", key_extended, mon_k.ext);
      end
    end
    if (frame_err) begin
      if (err_q.size() == 0) unexpected("err_unexpected", err_cnt);
      else check("err_cnt_at_err", err_cnt, err_q.pop_front());
    end
    raw_prev = raw_valid;
  end

  function automatic logic [10:0] frame(input logic [7:0] b, input logic pflip,
                                        input logic stop);
    return {stop, (~^b) ^ pflip, b, 1'b0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pflip = 1'b0,
                            input logic stop = 1'b1);
    send_bits(frame(b, pflip, stop), 11);
    ps2_data = 1'b1;
    idle(20);
  endtask

  task automatic push_raw(input logic [7:0] b);
    raw_q.push_back(b);
  endtask

  task automatic push_key(input logic [7:0] c, input logic p, input logic e);
    key_t k;
    k.code = c;
    k.pressed = p;
    k.ext = e;
    key_q.push_back(k);
  endtask

  task automatic good_key(input logic [7:0] b, input logic p, input logic e);
    push_raw(b);
    push_key(b, p, e);
    send_frame(b);
  endtask

  task automatic good_prefix(input logic [7:0] b);
    push_raw(b);
    send_frame(b);
  endtask

  initial begin
    repeat (150000) @(posedge clk_sys);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(4);
    check("rst_raw_valid", raw_valid, 0);
    check("rst_raw_byte", raw_byte, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_pressed", key_pressed, 0);
    check("rst_key_extended", key_extended, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    reset_n = 1'b1;
    idle(20);

    good_key(8'h1C, 1'b1, 1'b0);
    check("err_cnt_after_1c", err_cnt, 0);

    good_prefix(8'hE0);
    good_prefix(8'hF0);
    good_key(8'h75, 1'b0, 1'b1);
    good_key(8'h1C, 1'b1, 1'b0);

    good_prefix(8'hF0);
    good_prefix(8'hE0);
    good_key(8'h6B, 1'b0, 1'b1);

    good_prefix(8'hE0);
    good_prefix(8'hE0);
    good_key(8'h70, 1'b1, 1'b1);

    good_prefix(8'hF0);
    good_prefix(8'hFA);
    good_key(8'h1C, 1'b1, 1'b0);

    good_prefix(8'hAA);

    // Parity error inside an E0 sequence must clear the prefix.
    good_prefix(8'hE0);
    err_q.push_back(8'd1);
    send_frame(8'h1C, 1'b1, 1'b1);
    good_key(8'h1C, 1'b1, 1'b0);

    // Timeout on a 3-bit partial frame after F0.
    good_prefix(8'hF0);
    err_q.push_back(8'd2);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 3);
    ps2_data = 1'b1;
    idle(TO + 100);
    good_key(8'h1C, 1'b1, 1'b0);

    // Reset after the 5th data bit of 5A.
    send_bits(frame(8'h5A, 1'b0, 1'b1), 6);
    idle(3);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(1);
    check("err_cnt_after_reset", err_cnt, 0);
    ps2_data = 1'b1;
    idle(20);
    good_prefix(8'hAA);

    // Short clock glitches with data low must not start a frame.
    ps2_data = 1'b0;
    idle(10);
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      idle(2);
      ps2_clk = 1'b1;
      idle(10);
    end
    ps2_data = 1'b1;
    idle(TO + 100);

    for (int n = 1; n <= 256; n++) begin
      err_q.push_back((n > 255) ? 8'd255 : 8'(n));
      send_frame(8'h1C, 1'b0, 1'b0);
    end
    check("err_cnt_saturated", err_cnt, 255);

    idle(50);
    check("raw_q_drained", raw_q.size(), 0);
    check("key_q_drained", key_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
